// File: rtl/frame_buffer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : frame_buffer
// Purpose  : Double-buffered LED byte store between host byte stream and strip
//            driver; define FRAME_BUFFER_BRIGHTNESS_EN for brightness scaling.
// Revision : 1.0
// ============================================================================
module frame_buffer #(
  parameter int MAX_LEDS      = 3,
  parameter int NUM_CHANNELS  = 3,
  parameter int DEPTH         = MAX_LEDS * NUM_CHANNELS,
  parameter int ADDRESS_WIDTH = 13,
  parameter int BASE_ADDRESS  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [7:0]               wr_data,
  input  logic                     wr_last,
  input  logic                     mem_req,
  input  logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic                     mem_rdy,
  output logic [7:0]               mem_data,
  output logic                     frame_pending,
`ifdef FRAME_BUFFER_BRIGHTNESS_EN
  input  logic [7:0]               brightness,
`endif
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOOKUP  = 2'd1,
    SCALE   = 2'd2,
    RESPOND = 2'd3
  } state_t;

  state_t                   state;
  logic                     front;
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         idx;
  logic                     idx_ok;
  logic [7:0]               result;
  logic [7:0]               bank0 [DEPTH];
  logic [7:0]               bank1 [DEPTH];

  logic                     accept;
  logic                     in_space;
  logic [ADDRESS_WIDTH-1:0] offset;
  logic                     addr_ok;
  logic                     swap;

  assign wr_ready = ~frame_pending;
  assign accept   = wr_valid & wr_ready;
  assign in_space = (wr_ptr < PTR_W'(DEPTH));
  assign offset   = mem_addr - ADDRESS_WIDTH'(BASE_ADDRESS);
  assign addr_ok  = (mem_addr >= ADDRESS_WIDTH'(BASE_ADDRESS)) &&
                    (offset < ADDRESS_WIDTH'(DEPTH));
  // A frame restart (request for byte 0) is the only point where banks may swap.
  assign swap     = (state == IDLE) && mem_req && addr_ok &&
                    (offset == '0) && frame_pending;

  // Write side: fills the back bank and commits on wr_last.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      frame_pending <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      overflow <= accept && !in_space;
      if (accept) begin
        if (wr_last)
          wr_ptr <= '0;
        else if (in_space)
          wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (accept && wr_last)
        frame_pending <= 1'b1;
      else if (swap)
        frame_pending <= 1'b0;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (accept && in_space) begin
      if (front)
        bank0[wr_ptr] <= wr_data;
      else
        bank1[wr_ptr] <= wr_data;
    end
  end

  // Read side: IDLE -> LOOKUP -> (SCALE) -> RESPOND -> IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      front    <= 1'b0;
      idx      <= '0;
      idx_ok   <= 1'b0;
      result   <= 8'h00;
      mem_rdy  <= 1'b0;
      mem_data <= 8'h00;
    end else begin
      mem_rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_req) begin
            idx    <= offset[PTR_W-1:0];
            idx_ok <= addr_ok;
            state  <= LOOKUP;
            if (swap)
              front <= ~front;
          end
        end
        LOOKUP: begin
          if (!idx_ok)
            result <= 8'h00;
          else if (front)
            result <= bank1[idx];
          else
            result <= bank0[idx];
`ifdef FRAME_BUFFER_BRIGHTNESS_EN
          state <= SCALE;
`else
          state <= RESPOND;
`endif
        end
`ifdef FRAME_BUFFER_BRIGHTNESS_EN
        SCALE: begin
          result <= 8'((({8'h00, result}) * ({8'h00, brightness} + 16'd1)) >> 8);
          state  <= RESPOND;
        end
`endif
        RESPOND: begin
          mem_data <= result;
          mem_rdy  <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_buffer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_frame_buffer
// Purpose  : Directed self-checking bench for frame_buffer (DEPTH = 9).
// Revision : 1.0
// ============================================================================
module tb_frame_buffer;

`ifdef FRAME_BUFFER_BRIGHTNESS_EN
  localparam int EXP_LAT = 3;
`else
  localparam int EXP_LAT = 2;
`endif

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_last  = 1'b0;
  logic [7:0]  wr_data  = 8'h00;
  logic        mem_req  = 1'b0;
  logic [12:0] mem_addr = 13'h0;
  logic        wr_ready;
  logic        mem_rdy;
  logic [7:0]  mem_data;
  logic        frame_pending;
  logic        overflow;
`ifdef FRAME_BUFFER_BRIGHTNESS_EN
  logic [7:0]  brightness = 8'hFF;
`endif

  int tests    = 0;
  int fails    = 0;
  int ov_count = 0;
  int rdy_seen = 0;

  always #5 clk = ~clk;

  frame_buffer dut (
    .clk           (clk),
    .rst           (rst),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_data       (wr_data),
    .wr_last       (wr_last),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_rdy       (mem_rdy),
    .mem_data      (mem_data),
    .frame_pending (frame_pending),
`ifdef FRAME_BUFFER_BRIGHTNESS_EN
    .brightness    (brightness),
`endif
    .overflow      (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (overflow === 1'b1) ov_count++;
  endtask

  task automatic write_byte(input logic [7:0] d, input logic last);
    wr_valid = 1'b1;
    wr_data  = d;
    wr_last  = last;
    tick();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic write_frame(input logic [7:0] base, input int n, input logic inc);
    for (int i = 0; i < n; i++)
      write_byte(inc ? base + 8'(i) : base, (i == n - 1));
  endtask

  // Optionally presents a wr_last byte on the same edge the request is sampled.
  task automatic read_addr(input string tag, input logic [12:0] addr, input logic [7:0] exp,
                           input logic last_too, input logic [7:0] last_d);
    int lat;
    mem_req  = 1'b1;
    mem_addr = addr;
    if (last_too) begin
      wr_valid = 1'b1;
      wr_data  = last_d;
      wr_last  = 1'b1;
    end
    tick();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    lat = 0;
    while (mem_rdy !== 1'b1 && lat < 8) begin
      tick();
      lat++;
    end
    mem_req = 1'b0;
    check({tag, "_lat"}, lat, EXP_LAT);
    check({tag, "_data"}, {24'h0, mem_data}, {24'h0, exp});
    tick();
    check({tag, "_pulse"}, {31'h0, mem_rdy}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // T1 reset
    rst = 1'b1;
    tick();
    tick();
    check("rst_wr_ready", {31'h0, wr_ready}, 32'h1);
    check("rst_mem_rdy", {31'h0, mem_rdy}, 32'h0);
    check("rst_pending", {31'h0, frame_pending}, 32'h0);
    check("rst_overflow", {31'h0, overflow}, 32'h0);
    check("rst_mem_data", {24'h0, mem_data}, 32'h0);
    rst = 1'b0;
    tick();

    // T2 commit and swap
    write_frame(8'h10, 9, 1'b1);
    check("t2_pending", {31'h0, frame_pending}, 32'h1);
    check("t2_wr_ready", {31'h0, wr_ready}, 32'h0);
    read_addr("t2_a0", 13'd0, 8'h10, 1'b0, 8'h00);
    check("t2_swapped", {31'h0, frame_pending}, 32'h0);
    read_addr("t2_a8", 13'd8, 8'h18, 1'b0, 8'h00);
    check("t2_ready_back", {31'h0, wr_ready}, 32'h1);

    // T3 no tearing
    for (int a = 0; a < 5; a++)
      read_addr("t3_old", 13'(a), 8'h10 + 8'(a), 1'b0, 8'h00);
    write_frame(8'hAA, 9, 1'b0);
    check("t3_pending", {31'h0, frame_pending}, 32'h1);
    for (int a = 5; a < 9; a++)
      read_addr("t3_tail", 13'(a), 8'h10 + 8'(a), 1'b0, 8'h00);
    check("t3_still_pending", {31'h0, frame_pending}, 32'h1);
    read_addr("t3_new", 13'd0, 8'hAA, 1'b0, 8'h00);
    check("t3_swapped", {31'h0, frame_pending}, 32'h0);

    // T4 overflow
    ov_count = 0;
    write_frame(8'h30, 11, 1'b1);
    tick();
    check("t4_ov_pulses", ov_count, 2);
    check("t4_pending", {31'h0, frame_pending}, 32'h1);
    read_addr("t4_a0", 13'd0, 8'h30, 1'b0, 8'h00);
    read_addr("t4_a8", 13'd8, 8'h38, 1'b0, 8'h00);

    // Short frame: bytes past the end keep what that bank held before
    write_frame(8'h50, 3, 1'b1);
    read_addr("short_a0", 13'd0, 8'h50, 1'b0, 8'h00);
    read_addr("short_a2", 13'd2, 8'h52, 1'b0, 8'h00);
    read_addr("short_stale", 13'd3, 8'hAA, 1'b0, 8'h00);

    // T5 out of range
    write_frame(8'h60, 9, 1'b1);
    read_addr("t5_a9", 13'd9, 8'h00, 1'b0, 8'h00);
    check("t5_no_swap", {31'h0, frame_pending}, 32'h1);
    read_addr("t5_amax", 13'h1FFF, 8'h00, 1'b0, 8'h00);
    read_addr("t5_a0", 13'd0, 8'h60, 1'b0, 8'h00);
    check("t5_swapped", {31'h0, frame_pending}, 32'h0);

    // wr_last accepted on the same edge as a byte-0 request: no swap yet
    for (int i = 0; i < 8; i++)
      write_byte(8'h70 + 8'(i), 1'b0);
    read_addr("sim_a0", 13'd0, 8'h60, 1'b1, 8'h78);
    check("sim_pending", {31'h0, frame_pending}, 32'h1);
    read_addr("sim_next_a0", 13'd0, 8'h70, 1'b0, 8'h00);
    read_addr("sim_a8", 13'd8, 8'h78, 1'b0, 8'h00);

    // Reset mid-read aborts; RAM survives and front returns to bank 0
    mem_req  = 1'b1;
    mem_addr = 13'd1;
    tick();
    rst     = 1'b1;
    mem_req = 1'b0;
    tick();
    rst = 1'b0;
    rdy_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (mem_rdy === 1'b1) rdy_seen++;
    end
    check("abort_no_rdy", rdy_seen, 0);
    check("abort_pending", {31'h0, frame_pending}, 32'h0);
    read_addr("ram_kept", 13'd1, 8'h71, 1'b0, 8'h00);

`ifdef FRAME_BUFFER_BRIGHTNESS_EN
    // T6 brightness
    write_frame(8'hFF, 9, 1'b0);
    brightness = 8'h7F;
    read_addr("t6_half", 13'd0, 8'h7F, 1'b0, 8'h00);
    brightness = 8'hFF;
    read_addr("t6_full", 13'd1, 8'hFF, 1'b0, 8'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
